// File: rtl/divu_pkg.sv
// Shared types and widths for the iterative unsigned divider.
package divu_pkg;

  localparam int DIVU_W     = 32;
  localparam int DIVU_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divu_state_t;

endpackage : divu_pkg

// File: rtl/divu_iter_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface divu_iter_if;
  import divu_pkg::*;

  logic              start;
  logic [DIVU_W-1:0] dividend;
  logic [DIVU_W-1:0] divisor;
  logic              busy;
  logic              done;
  logic [DIVU_W-1:0] quotient;
  logic [DIVU_W-1:0] remainder;

  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder);
endinterface : divu_iter_if

// File: rtl/cla.sv
// 32-bit carry-lookahead adder: 4-bit groups with lookahead between groups.
module cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);
  logic [31:0] g, p, c;
  logic [6:0]  gg, gp;
  logic [7:0]  bc;

  // NOTE: every variable gets a value at the top of always_comb so no latch is inferred.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    bc = '0;
    c  = '0;
    for (int j = 0; j < 7; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    bc[0] = cin;
    for (int j = 0; j < 7; j++) bc[j+1] = gg[j] | (gp[j] & bc[j]);
    // Group carry-ins feed a short ripple inside each 4-bit group.
    for (int j = 0; j < 8; j++) begin
      c[4*j] = bc[j];
      for (int k = 1; k < 4; k++)
        c[4*j+k] = g[4*j+k-1] | (p[4*j+k-1] & c[4*j+k-1]);
    end
    sum = p ^ c;
  end
endmodule : cla

// File: rtl/divu_step.sv
// One restoring-division step: trial subtract through cla, carry-out rebuilt from bit 31.
module divu_step
  import divu_pkg::*;
(
  input  logic [DIVU_W-1:0] rem,
  input  logic              dvd_msb,
  input  logic [DIVU_W-1:0] dvs,
  output logic [DIVU_W-1:0] rem_next,
  output logic              take
);
  logic [DIVU_W-1:0] sh, dvs_n, diff;
  logic              c31, co;

  assign sh    = {rem[DIVU_W-2:0], dvd_msb};
  assign dvs_n = ~dvs;

  cla u_cla (
    .a   (sh),
    .b   (dvs_n),
    .cin (1'b1),
    .sum (diff)
  );

  // cla exposes no carry-out, so recover the carry into bit 31 and regenerate it.
  assign c31 = diff[DIVU_W-1] ^ sh[DIVU_W-1] ^ dvs_n[DIVU_W-1];
  assign co  = (sh[DIVU_W-1] & dvs_n[DIVU_W-1]) | ((sh[DIVU_W-1] | dvs_n[DIVU_W-1]) & c31);

  // A set rem MSB means the shifted value overflowed 32 bits and exceeds any divisor.
  assign take     = rem[DIVU_W-1] | co;
  assign rem_next = take ? diff : sh;
endmodule : divu_step

// File: rtl/divu_iter.sv
// Iterative 32-bit unsigned divider: FSM, iteration counter and result registers.
module divu_iter
  import divu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  divu_iter_if.slave  bus
);
  divu_state_t           state_q, state_d;
  logic [DIVU_W-1:0]     dvd_q, dvs_q, rem_q, quot_q, rmdr_q;
  logic [DIVU_CNT_W-1:0] cnt_q;
  logic [DIVU_W-1:0]     rem_next;
  logic                  take, accept, last;

  divu_step u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[DIVU_W-1]),
    .dvs      (dvs_q),
    .rem_next (rem_next),
    .take     (take)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = BUSY;
        accept  = 1'b1;
      end
      BUSY: if (cnt_q == DIVU_CNT_W'(DIVU_W - 1)) begin
        state_d = DONE;
        last    = 1'b1;
      end
      DONE: begin
        state_d = bus.start ? BUSY : IDLE;
        accept  = bus.start;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rmdr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dvd_q <= bus.dividend;
        dvs_q <= bus.divisor;
        rem_q <= '0;
        cnt_q <= '0;
      end else if (state_q == BUSY) begin
        dvd_q <= {dvd_q[DIVU_W-2:0], take};
        rem_q <= rem_next;
        cnt_q <= cnt_q + DIVU_CNT_W'(1);
      end
      // Results load straight from the final step so they are valid in the DONE cycle.
      if (last) begin
        quot_q <= {dvd_q[DIVU_W-2:0], take};
        rmdr_q <= rem_next;
      end
    end
  end

  assign bus.busy      = (state_q == BUSY);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = rmdr_q;
endmodule : divu_iter
